// File: rtl/isa_pkg.sv
// isa_pkg: shared stage/state encodings and opcode constants for the sequencer and decoder
package isa_pkg;
  typedef enum logic [1:0] {
    STG_FETCH  = 2'b00,
    STG_EXEC   = 2'b01,
    STG_RETIRE = 2'b10
  } stage_t;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } seq_state_t;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_BR   = 4'h2;
  localparam logic [3:0] OP_JMP  = 4'h3;
  localparam logic [3:0] OP_CALL = 4'h4;
  localparam logic [3:0] OP_RET  = 4'h5;
  localparam logic [3:0] OP_HALT = 4'hf;
endpackage

// File: rtl/ret_stack.sv
// ret_stack: return-address LIFO; dout shows the top entry, push/pop beyond full/empty are ignored
module ret_stack #(
  parameter int PCW = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clr,
  input  logic           push,
  input  logic           pop,
  input  logic [PCW-1:0] din,
  output logic [PCW-1:0] dout,
  output logic           full,
  output logic           empty
);
  localparam int AW = $clog2(STACK_DEPTH);
  logic [AW:0] sp;
  logic [AW-1:0] rd;
  logic [PCW-1:0] mem [STACK_DEPTH];
  assign rd = sp[AW-1:0] - 1'b1;
  assign dout = mem[rd];
  assign full = sp == (AW+1)'(STACK_DEPTH);
  assign empty = sp == '0;
  // stack pointer: cleared on reset or restart, moves one slot per push/pop
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sp <= '0;
    else if (clr) sp <= '0;
    else if (push && !full) sp <= sp + 1'b1;
    else if (pop && !empty) sp <= sp - 1'b1;
  // storage: write the pushed address into the next free slot
  always_ff @(posedge clk)
    if (push && !full && !clr) mem[sp[AW-1:0]] <= din;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: 3-stage instruction sequencer with pc, return stack and run/halt FSM; optional PC_SEQ_STALL_EN adds a stall input
module pc_sequencer
  import isa_pkg::*;
#(
  parameter int PCW = 10,
  parameter int STACK_DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           jump,
  input  logic           call,
  input  logic           ret,
  input  logic           take,
  input  logic           halt,
  input  logic [PCW-1:0] target,
`ifdef PC_SEQ_STALL_EN
  input  logic           stall,
`endif
  output logic [PCW-1:0] pc,
  output logic [1:0]     stage,
  output logic           done,
  output logic           stack_err
);
  seq_state_t state;
  stage_t stg;
  logic go, retire, launch, full, empty, under, over, push, pop;
  logic [PCW-1:0] top, pc_inc, next_pc;
`ifdef PC_SEQ_STALL_EN
  assign go = !stall;
`else
  assign go = 1'b1;
`endif
  assign stage = stg;
  assign launch = start && state != RUN;
  assign retire = state == RUN && stg == STG_RETIRE && go;
  assign pc_inc = pc + 1'b1;
  assign under = ret && empty;
  assign over = !ret && call && full;
  assign push = retire && !halt && !ret && call && !full;
  assign pop = retire && !halt && ret && !empty;
  assign next_pc = ret ? top : call ? target : (jump && take) ? target : pc_inc;
  ret_stack #(.PCW(PCW), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk(clk), .reset_n(reset_n), .clr(launch), .push(push), .pop(pop),
    .din(pc_inc), .dout(top), .full(full), .empty(empty)
  );
  // run/halt FSM, stage counter and pc register; pc only moves on the retire edge
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pc <= '0;
      stg <= STG_FETCH;
      done <= 1'b0;
      stack_err <= 1'b0;
    end else if (launch) begin
      state <= RUN;
      pc <= '0;
      stg <= STG_FETCH;
      done <= 1'b0;
      stack_err <= 1'b0;
    end else if (state == RUN && go) begin
      if (stg != STG_RETIRE) stg <= (stg == STG_FETCH) ? STG_EXEC : STG_RETIRE;
      else begin
        stg <= STG_FETCH;
        if (halt) begin
          state <= HALTED;
          done <= 1'b1;
        end else if (under || over) begin
          state <= HALTED;
          stack_err <= 1'b1;
        end else pc <= next_pc;
      end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed checks of stage sequencing, jumps, call/ret stack, errors, halt and async reset
module tb_pc_sequencer;
  logic clk = 1'b0, reset_n, start, jump, call, ret, take, halt;
  logic [9:0] target, pc;
  logic [1:0] stage;
  logic done, stack_err;
  int checks = 0, failures = 0;

  pc_sequencer #(.PCW(10), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .jump(jump), .call(call),
    .ret(ret), .take(take), .halt(halt), .target(target),
    .pc(pc), .stage(stage), .done(done), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input int e_pc, input int e_stage, input int e_done, input int e_err);
    chk({tag, ".pc"}, 32'(pc), e_pc);
    chk({tag, ".stage"}, 32'(stage), e_stage);
    chk({tag, ".done"}, 32'(done), e_done);
    chk({tag, ".err"}, 32'(stack_err), e_err);
  endtask

  task automatic ins(input logic j, input logic c, input logic r, input logic tk, input logic h, input int tgt);
    jump = j; call = c; ret = r; take = tk; halt = h; target = 10'(tgt);
    repeat (3) @(negedge clk);
    jump = 0; call = 0; ret = 0; take = 0; halt = 0; target = '0;
  endtask

  task automatic kick();
    start = 1; @(negedge clk); start = 0;
  endtask

  initial begin
    reset_n = 0; start = 0; jump = 0; call = 0; ret = 0; take = 0; halt = 0; target = '0;
    repeat (2) @(negedge clk);
    st("reset", 0, 0, 0, 0);
    reset_n = 1;
    @(negedge clk); st("idle", 0, 0, 0, 0);
    kick(); st("run0", 0, 0, 0, 0);
    @(negedge clk); st("s01", 0, 1, 0, 0);
    @(negedge clk); st("s10", 0, 2, 0, 0);
    @(negedge clk); st("i1", 1, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0); st("i2", 2, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0); st("i3", 3, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0); st("i4", 4, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0); st("i5", 5, 0, 0, 0);
    ins(1, 0, 0, 0, 0, 40); st("jnt", 6, 0, 0, 0);
    ins(1, 0, 0, 1, 0, 40); st("jt", 40, 0, 0, 0);
    ins(1, 0, 0, 1, 0, 7); st("j7", 7, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 100); st("call", 100, 0, 0, 0);
    ins(1, 0, 1, 0, 0, 0); st("ret", 8, 0, 0, 0);
    ins(1, 0, 1, 0, 0, 0); st("under", 8, 0, 0, 1);
    @(negedge clk); st("under_hold", 8, 0, 0, 1);
    kick(); st("restart", 0, 0, 0, 0);
    start = 1; ins(0, 0, 0, 0, 0, 0); start = 0; st("start_ign", 1, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 20); st("c1", 20, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 30); st("c2", 30, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 40); st("c3", 40, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 50); st("c4", 50, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 60); st("over", 50, 0, 0, 1);
    @(negedge clk); st("over_hold", 50, 0, 0, 1);
    kick(); st("restart2", 0, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 20); st("n1", 20, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 30); st("n2", 30, 0, 0, 0);
    ins(1, 0, 1, 0, 0, 0); st("r2", 21, 0, 0, 0);
    ins(1, 0, 1, 0, 0, 0); st("r1", 1, 0, 0, 0);
    ins(1, 0, 0, 1, 0, 1023); st("jmax", 1023, 0, 0, 0);
    ins(0, 0, 0, 0, 0, 0); st("wrap", 0, 0, 0, 0);
    ins(1, 0, 0, 1, 0, 12); st("j12", 12, 0, 0, 0);
    ins(1, 0, 0, 1, 1, 99); st("halt", 12, 0, 1, 0);
    @(negedge clk); st("halt_hold", 12, 0, 1, 0);
    kick(); st("restart3", 0, 0, 0, 0);
    ins(1, 1, 0, 0, 0, 100); st("c100", 100, 0, 0, 0);
    @(negedge clk); st("pre_rst", 100, 1, 0, 0);
    #2 reset_n = 0;
    #1 st("async_rst", 0, 0, 0, 0);
    @(negedge clk); reset_n = 1;
    @(negedge clk); st("post_rst", 0, 0, 0, 0);
    kick();
    ins(1, 0, 1, 0, 0, 0); st("rst_empty", 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
